// File: rtl/bit_stuffer.sv
// USB-style bit stuffer: inserts a 0 after every RUN_LEN consecutive 1s in the
// serial packet coming from the CRC stage. It passes bits straight through, so
// there is no added latency. Upstream is stalled for one cycle per stuffed bit.
module bit_stuffer #(
  parameter int RUN_LEN = 6,   // legal range 2..15
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_L,
  input  logic             inb,
  input  logic             recving,
  input  logic             pause_out,
  output logic             pause_in,
  output logic             outb,
  output logic             sending,
  output logic [CNT_W-1:0] stuff_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PASS  = 2'd1;
  localparam logic [1:0] STUFF = 2'd2;

  localparam logic [3:0]       RUN_MAX = 4'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [3:0]       ones_q, ones_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       ones_eff;

  assign stuff_count = cnt_q;

  // Output decode. Outputs are forced low while reset is held, so a reset
  // landing on a live packet silences the line immediately.
  always_comb begin
    outb     = 1'b0;
    sending  = 1'b0;
    pause_in = pause_out;
    case (state_q)
      IDLE:  if (recving) begin
               outb    = inb;
               sending = 1'b1;
             end
      PASS:  begin
               outb    = inb;
               sending = recving;
             end
      STUFF: begin
               outb     = 1'b0;
               sending  = 1'b1;
               pause_in = 1'b1;
             end
      default: ;
    endcase
    if (!rst_L) begin
      outb     = 1'b0;
      sending  = 1'b0;
      pause_in = 1'b0;
    end
  end

  // Next-state logic. IDLE with recving behaves like PASS with a fresh run,
  // so the first bit of a packet is never lost.
  always_comb begin
    state_d  = state_q;
    ones_d   = ones_q;
    cnt_d    = cnt_q;
    ones_eff = (state_q == IDLE) ? 4'd0 : ones_q;
    if (!pause_out) begin
      case (state_q)
        IDLE, PASS: begin
          if (state_q == IDLE && recving) cnt_d = '0;
          if (!recving) begin
            state_d = IDLE;
            ones_d  = 4'd0;
          end else if (!inb) begin
            state_d = PASS;
            ones_d  = 4'd0;
          end else if (ones_eff == RUN_MAX) begin
            state_d = STUFF;
            ones_d  = 4'd0;
          end else begin
            state_d = PASS;
            ones_d  = ones_eff + 4'd1;
          end
        end
        STUFF: begin
          // The stuffed 0 restarts the run; upstream held its bit meanwhile.
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
          ones_d  = 4'd0;
          state_d = recving ? PASS : IDLE;
        end
        default: begin
          state_d = IDLE;
          ones_d  = 4'd0;
        end
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q <= IDLE;
      ones_q  <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bit_stuffer.sv
// Bench for bit_stuffer: a driver plays packets through an upstream model that
// honours pause_in; a scoreboard monitor checks every emitted bit and the
// pause_in flag against a stuffed stream computed from the packet contents.
module tb_bit_stuffer;
  localparam int RUN_LEN = 6;
  localparam int CNT_W   = 8;

  logic clk = 1'b0;
  logic rst_L = 1'b0;
  logic inb = 1'b0, recving = 1'b0, pause_out = 1'b0;
  logic pause_in, outb, sending;
  logic [CNT_W-1:0] stuff_count;

  typedef struct packed { logic b; logic stf; } exp_t;
  exp_t expq[$];
  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  bit_stuffer #(.RUN_LEN(RUN_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_L(rst_L), .inb(inb), .recving(recving),
    .pause_out(pause_out), .pause_in(pause_in), .outb(outb),
    .sending(sending), .stuff_count(stuff_count)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: one expected bit consumed per step that shows a bit.
  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_en && rst_L) begin
      if (sending && !pause_out) begin
        tests++;
        if (expq.size() == 0) begin
          fails++;
          $display("FAIL extra_bit: outb=%0b sending=1 with no bit expected", outb);
        end else begin
          e = expq.pop_front();
          if (outb !== e.b || pause_in !== e.stf) begin
            fails++;
            $display("FAIL stream_bit: got outb=%0b pause_in=%0b, want outb=%0b pause_in=%0b",
                     outb, pause_in, e.b, e.stf);
          end
        end
      end else begin
        tests++;
        if (pause_in !== pause_out) begin
          fails++;
          $display("FAIL pause_in_idle: got %0b want %0b", pause_in, pause_out);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Drive one packet. The expected stream is derived from the stuffing rule:
  // after RUN_LEN ones in a row, a 0 is inserted and the run starts over.
  task automatic send_pkt(input bit pkt[$], input int pprob);
    int idx = 0, nst = 0, run = 0, budget;
    bit take, done;
    exp_t e;
    foreach (pkt[i]) begin
      e.b = pkt[i]; e.stf = 1'b0; expq.push_back(e);
      if (pkt[i]) begin
        run++;
        if (run == RUN_LEN) begin
          e.b = 1'b0; e.stf = 1'b1; expq.push_back(e);
          run = 0; nst++;
        end
      end else run = 0;
    end
    budget = pkt.size() * 20 + 100;
    while (idx < pkt.size() && budget > 0) begin
      recving   = 1'b1;
      inb       = pkt[idx];
      pause_out = ($urandom_range(99) < pprob);
      @(negedge clk);
      take = !pause_in;
      @(posedge clk); #1;
      if (take) idx++;
      budget--;
    end
    recving = 1'b0;
    inb     = 1'b0;
    done    = 1'b0;
    while (!done && budget > 0) begin
      pause_out = ($urandom_range(99) < pprob);
      @(negedge clk);
      done = !sending && !pause_out;
      @(posedge clk); #1;
      budget--;
    end
    pause_out = 1'b0;
    check("pkt_timeout", (budget > 0) ? 1 : 0, 1);
    check("stuff_count", int'(stuff_count), (nst > 255) ? 255 : nst);
    check("stream_drained", expq.size(), 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit p[$];
    repeat (2) @(posedge clk);
    #1;
    check("rst_outb", outb, 0);
    check("rst_sending", sending, 0);
    check("rst_pause_in", pause_in, 0);
    check("rst_stuff_count", int'(stuff_count), 0);
    rst_L  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // six ones then zeros
    p = {1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    send_pkt(p, 0);
    // runs of five never stuff
    p = {1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0};
    send_pkt(p, 0);
    // twelve ones -> two stuffs
    p = {};
    repeat (12) p.push_back(1);
    send_pkt(p, 0);
    // packet ends on a completed run
    p = {1, 1, 1, 1, 1, 1};
    send_pkt(p, 0);
    send_pkt(p, 50);
    // long run of ones saturates the counter
    p = {};
    repeat (RUN_LEN * 260) p.push_back(1);
    send_pkt(p, 0);
    // random packets with random downstream stalls
    for (int k = 0; k < 40; k++) begin
      p = {};
      for (int j = 0; j < int'($urandom_range(40, 1)); j++)
        p.push_back($urandom_range(99) < 75);
      send_pkt(p, int'($urandom_range(40)));
    end

    // reset landing in the STUFF cycle
    mon_en = 1'b0;
    recving = 1'b1; inb = 1'b1; pause_out = 1'b0;
    repeat (RUN_LEN) begin @(posedge clk); #1; end
    @(negedge clk);
    check("stuff_sending", sending, 1);
    check("stuff_pause_in", pause_in, 1);
    check("stuff_outb", outb, 0);
    rst_L = 1'b0;
    #1;
    check("abort_outb", outb, 0);
    check("abort_sending", sending, 0);
    check("abort_pause_in", pause_in, 0);
    check("abort_stuff_count", int'(stuff_count), 0);
    recving = 1'b0; inb = 1'b0;
    @(posedge clk); #1;
    rst_L = 1'b1;
    expq.delete();
    mon_en = 1'b1;
    @(posedge clk); #1;
    p = {1, 1, 1, 1, 1, 1, 1, 0};
    send_pkt(p, 20);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
